// File: rtl/bcd_pkg.sv
// Shared types and constants for the time-shared binary-to-BCD decode path.
package bcd_pkg;
  localparam int NUM_W              = 7;
  localparam int BCD_W              = 8;
  localparam logic [7:0] BCD_ERR_CODE = 8'hBB;
  localparam int BCD_MAX_VAL        = 81;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, CAPTURE} state_e;

  // A result is bad if the decoder flagged it or the issued number was out of range.
  function automatic logic result_err(input logic [BCD_W-1:0] bcd,
                                      input logic [NUM_W-1:0] num,
                                      input int               max_val);
    return (bcd == BCD_ERR_CODE) || (int'(num) > max_val);
  endfunction
endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first requester at or after the pointer wins.
module rr_arbiter #(
  parameter int N  = 4,
  parameter int IW = $clog2(N)
) (
  input  logic [N-1:0]  req_i,
  input  logic [IW-1:0] ptr_i,
  output logic [N-1:0]  gnt_o,
  output logic [IW-1:0] idx_o
);
  logic [IW:0] pos;
  logic        found;

  always_comb begin
    gnt_o = '0;
    idx_o = '0;
    found = 1'b0;
    pos   = '0;
    for (int k = 0; k < N; k++) begin
      pos = {1'b0, ptr_i} + (IW+1)'(k);
      if (pos >= (IW+1)'(N)) pos = pos - (IW+1)'(N);
      if (!found && req_i[pos[IW-1:0]]) begin
        found                = 1'b1;
        gnt_o[pos[IW-1:0]]   = 1'b1;
        idx_o                = pos[IW-1:0];
      end
    end
  end
endmodule

// File: rtl/bcd_decode_arbiter.sv
// Round-robin sharing of one external registered BCD decoder among N_SRC requesters,
// with req/gnt/done handshake and source-tagged, error-flagged results.
module bcd_decode_arbiter
  import bcd_pkg::*;
#(
  parameter int N_SRC   = 4,
  parameter int DEC_LAT = 1,
  parameter int MAX_VAL = BCD_MAX_VAL,
  parameter int SW      = $clog2(N_SRC)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [N_SRC-1:0]       req,
  input  logic [NUM_W*N_SRC-1:0] num_in,
  output logic [N_SRC-1:0]       gnt,
  output logic [N_SRC-1:0]       done,
  output logic [BCD_W-1:0]       bcd_out,
  output logic                   bcd_err,
  output logic [SW-1:0]          bcd_src,
  output logic                   busy,
  output logic [NUM_W-1:0]       dec_num,
  input  logic [BCD_W-1:0]       dec_bcd
);
  localparam int WCW = (DEC_LAT > 2) ? $clog2(DEC_LAT - 1) : 1;

  state_e             state_q;
  logic [SW-1:0]      ptr_q, src_q, bcd_src_q;
  logic [NUM_W-1:0]   num_q;
  logic [N_SRC-1:0]   gnt_q, done_q;
  logic [BCD_W-1:0]   bcd_q;
  logic               err_q, busy_q;
  logic [WCW-1:0]     wcnt_q;

  logic [N_SRC-1:0]   win_gnt;
  logic [SW-1:0]      win_idx;
  logic [NUM_W-1:0]   sel_num;

  rr_arbiter #(.N(N_SRC), .IW(SW)) u_arb (
    .req_i (req),
    .ptr_i (ptr_q),
    .gnt_o (win_gnt),
    .idx_o (win_idx)
  );

  always_comb begin
    sel_num = '0;
    for (int i = 0; i < N_SRC; i++)
      if (win_idx == SW'(i)) sel_num = num_in[i*NUM_W +: NUM_W];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      ptr_q     <= '0;
      src_q     <= '0;
      bcd_src_q <= '0;
      num_q     <= '0;
      gnt_q     <= '0;
      done_q    <= '0;
      bcd_q     <= '0;
      err_q     <= 1'b0;
      busy_q    <= 1'b0;
      wcnt_q    <= '0;
    end else begin
      gnt_q  <= '0;
      done_q <= '0;
      unique case (state_q)
        // The IDLE cycle carrying done is a turnaround cycle: no grant until the next one,
        // which paces back-to-back conversions at DEC_LAT+3 cycles.
        IDLE: begin
          if (~|done_q && |req) begin
            src_q   <= win_idx;
            num_q   <= sel_num;
            gnt_q   <= win_gnt;
            busy_q  <= 1'b1;
            state_q <= ISSUE;
          end
        end
        ISSUE: begin
          wcnt_q  <= '0;
          state_q <= (DEC_LAT == 1) ? CAPTURE : WAIT;
        end
        WAIT: begin
          if (int'(wcnt_q) == DEC_LAT - 2) state_q <= CAPTURE;
          else                             wcnt_q  <= wcnt_q + 1'b1;
        end
        CAPTURE: begin
          bcd_q     <= dec_bcd;
          bcd_src_q <= src_q;
          err_q     <= result_err(dec_bcd, num_q, MAX_VAL);
          done_q    <= N_SRC'(1) << src_q;
          ptr_q     <= (src_q == SW'(N_SRC - 1)) ? '0 : src_q + 1'b1;
          busy_q    <= 1'b0;
          state_q   <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign gnt     = gnt_q;
  assign done    = done_q;
  assign bcd_out = bcd_q;
  assign bcd_err = err_q;
  assign bcd_src = bcd_src_q;
  assign busy    = busy_q;
  assign dec_num = num_q;
endmodule

// File: tb/tb_bcd_decode_arbiter.sv
// Bench for bcd_decode_arbiter: directed vectors against a behavioural decoder model,
// one DUT with DEC_LAT=1 and one with DEC_LAT=3.
module tb_bcd_decode_arbiter;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [3:0]  req_a = '0, gnt_a, done_a;
  logic [27:0] num_a = '0;
  logic [7:0]  bcd_a, dbcd_a;
  logic [6:0]  dnum_a;
  logic [1:0]  src_a;
  logic        err_a, busy_a;

  logic [3:0]  req_b = '0, gnt_b, done_b;
  logic [27:0] num_b = '0;
  logic [7:0]  bcd_b, dbcd_b;
  logic [6:0]  dnum_b;
  logic [1:0]  src_b;
  logic        err_b, busy_b;

  bcd_decode_arbiter #(.N_SRC(4), .DEC_LAT(1), .MAX_VAL(81)) dut_a (
    .clk(clk), .rst(rst), .req(req_a), .num_in(num_a), .gnt(gnt_a), .done(done_a),
    .bcd_out(bcd_a), .bcd_err(err_a), .bcd_src(src_a), .busy(busy_a),
    .dec_num(dnum_a), .dec_bcd(dbcd_a));

  bcd_decode_arbiter #(.N_SRC(4), .DEC_LAT(3), .MAX_VAL(81)) dut_b (
    .clk(clk), .rst(rst), .req(req_b), .num_in(num_b), .gnt(gnt_b), .done(done_b),
    .bcd_out(bcd_b), .bcd_err(err_b), .bcd_src(src_b), .busy(busy_b),
    .dec_num(dnum_b), .dec_bcd(dbcd_b));

  function automatic logic [7:0] dec_f(input logic [6:0] n);
    if (n > 7'd81) return 8'hBB;
    return {4'(n / 7'd10), 4'(n % 7'd10)};
  endfunction

  logic [7:0] pipe_b [3];
  always_ff @(posedge clk) begin
    dbcd_a    <= dec_f(dnum_a);
    pipe_b[0] <= dec_f(dnum_b);
    pipe_b[1] <= pipe_b[0];
    pipe_b[2] <= pipe_b[1];
  end
  assign dbcd_b = pipe_b[2];

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // One isolated transaction on DUT A starting at the next negedge (cycle t).
  task automatic run_a(input int src, input int num, input logic [7:0] ebcd,
                       input logic eerr, input string tag);
    logic [31:0] oh;
    oh = 32'(1) << src;
    @(negedge clk);
    req_a = '0;
    req_a[src] = 1'b1;
    num_a[7*src +: 7] = 7'(num);
    @(negedge clk);
    chk({tag, " gnt"}, 32'(gnt_a), oh);
    chk({tag, " busy"}, 32'(busy_a), 32'd1);
    chk({tag, " dec_num"}, 32'(dnum_a), 32'(num));
    req_a = '0;
    @(negedge clk);
    chk({tag, " quiet"}, {24'd0, gnt_a, done_a}, 32'd0);
    @(negedge clk);
    chk({tag, " done"}, 32'(done_a), oh);
    chk({tag, " bcd"}, 32'(bcd_a), 32'(ebcd));
    chk({tag, " err"}, 32'(err_a), 32'(eerr));
    chk({tag, " src"}, 32'(src_a), 32'(src));
    chk({tag, " busy_end"}, 32'(busy_a), 32'd0);
  endtask

  typedef struct {
    int         src;
    int         num;
    logic [7:0] bcd;
    logic       err;
  } vec_t;
  vec_t vecs [7];

  initial begin
    vecs[0] = '{2, 47,  8'h47, 1'b0};
    vecs[1] = '{0, 81,  8'h81, 1'b0};
    vecs[2] = '{0, 82,  8'hBB, 1'b1};
    vecs[3] = '{0, 0,   8'h00, 1'b0};
    vecs[4] = '{1, 9,   8'h09, 1'b0};
    vecs[5] = '{3, 127, 8'hBB, 1'b1};
    vecs[6] = '{3, 80,  8'h80, 1'b0};

    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset outputs", {gnt_a, done_a, bcd_a, 7'd0, err_a, src_a, busy_a, dnum_a}, 32'd0);
    chk("reset busy_b", 32'(busy_b), 32'd0);
    rst = 1'b0;

    // Single transactions, including range boundaries and pointer wrap.
    for (int i = 0; i < 7; i++)
      run_a(vecs[i].src, vecs[i].num, vecs[i].bcd, vecs[i].err, $sformatf("vec%0d", i));

    // All four request together; pointer is 0, so grants go 0,1,2,3, four cycles apart.
    @(negedge clk);
    @(negedge clk);
    req_a = 4'b1111;
    num_a = {7'd40, 7'd30, 7'd20, 7'd10};
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk($sformatf("rr gnt%0d", k), 32'(gnt_a), 32'(1) << k);
      req_a[k] = 1'b0;
      @(negedge clk);
      @(negedge clk);
      chk($sformatf("rr done%0d", k), 32'(done_a), 32'(1) << k);
      chk($sformatf("rr bcd%0d", k), 32'(bcd_a), 32'({4'(k + 1), 4'd0}));
      @(negedge clk);
      chk($sformatf("rr gap%0d", k), 32'(gnt_a), 32'd0);
    end

    // src0 re-requests immediately; src3 waiting must win before src0 again.
    @(negedge clk);
    req_a = 4'b0001;
    num_a[6:0] = 7'd5;
    @(negedge clk);
    chk("fair gnt0", 32'(gnt_a), 32'h1);
    req_a = 4'b1000;
    num_a[27:21] = 7'd33;
    @(negedge clk);
    req_a = 4'b1001;
    num_a[6:0] = 7'd6;
    @(negedge clk);
    chk("fair done0", 32'(done_a), 32'h1);
    chk("fair bcd0", 32'(bcd_a), 32'h05);
    @(negedge clk);
    chk("fair turn", 32'(gnt_a), 32'h0);
    @(negedge clk);
    chk("fair gnt3", 32'(gnt_a), 32'h8);
    req_a[3] = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("fair done3", 32'(done_a), 32'h8);
    chk("fair bcd3", 32'(bcd_a), 32'h33);
    chk("fair src3", 32'(src_a), 32'd3);
    @(negedge clk);
    @(negedge clk);
    chk("fair gnt0b", 32'(gnt_a), 32'h1);
    req_a = '0;
    @(negedge clk);
    @(negedge clk);
    chk("fair bcd0b", 32'(bcd_a), 32'h06);

    // Reset during CAPTURE aborts the transaction without done.
    @(negedge clk);
    @(negedge clk);
    req_a = 4'b0100;
    num_a[20:14] = 7'd12;
    @(negedge clk);
    chk("abort gnt", 32'(gnt_a), 32'h4);
    req_a = '0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("abort outputs", {gnt_a, done_a, bcd_a, 7'd0, err_a, src_a, busy_a, dnum_a}, 32'd0);
    @(negedge clk);
    chk("abort no done", 32'(done_a), 32'd0);
    run_a(1, 64, 8'h64, 1'b0, "post-reset");

    // DEC_LAT=3 instance: done at t+5, busy over t+1..t+4.
    @(negedge clk);
    req_b = 4'b0001;
    num_b[6:0] = 7'd59;
    @(negedge clk);
    chk("lat3 gnt", 32'(gnt_b), 32'h1);
    chk("lat3 busy1", 32'(busy_b), 32'd1);
    req_b = '0;
    for (int c = 2; c <= 4; c++) begin
      @(negedge clk);
      chk($sformatf("lat3 busy%0d", c), 32'(busy_b), 32'd1);
      chk($sformatf("lat3 nodone%0d", c), 32'(done_b), 32'd0);
    end
    @(negedge clk);
    chk("lat3 done", 32'(done_b), 32'h1);
    chk("lat3 bcd", 32'(bcd_b), 32'h59);
    chk("lat3 err", 32'(err_b), 32'd0);
    chk("lat3 busy5", 32'(busy_b), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
